// File: rtl/adam_fabric_pause_seq_pkg.sv
// Shared definitions for the fabric pause sequencer: state codes and the
// timeout counter width helper.
package adam_fabric_pause_seq_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE        = 2'd0;
   localparam state_t PAUSE_STEP  = 2'd1;
   localparam state_t PAUSED      = 2'd2;
   localparam state_t RESUME_STEP = 2'd3;

   // Width needed to count 0..timeout, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/adam_fabric_pause_seq_if.sv
// Upstream/downstream pause handshake bundle of one clock domain.
interface adam_fabric_pause_seq_if #(
   parameter int unsigned NO_CHANS = 3
);
   logic                pause_req_i;
   logic                pause_ack_o;
   logic [NO_CHANS-1:0] chan_en_i;
   logic [NO_CHANS-1:0] chan_req_o;
   logic [NO_CHANS-1:0] chan_ack_i;
   logic                busy_o;
   logic [NO_CHANS-1:0] err_o;
   logic                err_clr_i;

   modport master (
      output pause_req_i, chan_en_i, chan_ack_i, err_clr_i,
      input  pause_ack_o, chan_req_o, busy_o, err_o
   );

   modport slave (
      input  pause_req_i, chan_en_i, chan_ack_i, err_clr_i,
      output pause_ack_o, chan_req_o, busy_o, err_o
   );
endinterface

// File: rtl/adam_fabric_pause_timer.sv
// Per-step wait counter: cleared on step entry, counts waiting cycles and
// pulses timeout_o on the last permitted waiting cycle (TIMEOUT=0: never).
module adam_fabric_pause_timer
   import adam_fabric_pause_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 1024,
   parameter int unsigned CNT_WIDTH = cnt_width(TIMEOUT)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);

   logic [CNT_WIDTH-1:0] cnt_q;

   // count waiting cycles; a clear takes priority over counting
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
   end

   // fire while still waiting once the count has reached TIMEOUT-1
   always_comb begin
      timeout_o = 1'b0;
      if (TIMEOUT != 0) begin
         timeout_o = en_i && (cnt_q == CNT_WIDTH'(TIMEOUT - 1));
      end
   end

endmodule

// File: rtl/adam_fabric_pause_seq.sv
// Fabric pause sequencer: requests enabled channels in ascending order on
// pause, releases them in descending order on resume, with a per-step
// timeout and sticky per-channel error flags.
module adam_fabric_pause_seq
   import adam_fabric_pause_seq_pkg::*;
#(
   parameter int unsigned NO_CHANS = 3,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   adam_fabric_pause_seq_if.slave bus
);

   localparam int unsigned CNT_WIDTH = cnt_width(TIMEOUT);
   localparam int unsigned IDX_W     = (NO_CHANS > 1) ? $clog2(NO_CHANS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_CHANS - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NO_CHANS-1:0] en_q, en_d;
   logic [NO_CHANS-1:0] req_q, req_d;
   logic [NO_CHANS-1:0] err_q, err_d, err_set;
   logic                abort_q, abort_d;
   logic                ack_q, ack_d;
   logic                busy_q;
   logic                in_step, ack_done, step_done, timeout;

   // a step is finished by a skipped channel, the expected ack level or a timeout
   always_comb begin
      in_step   = (state_q == PAUSE_STEP) || (state_q == RESUME_STEP);
      ack_done  = !en_q[idx_q] || (bus.chan_ack_i[idx_q] == (state_q == PAUSE_STEP));
      step_done = in_step && (ack_done || timeout);
   end

   adam_fabric_pause_timer #(
      .TIMEOUT   (TIMEOUT),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (!in_step || step_done),
      .en_i      (in_step && !ack_done),
      .timeout_o (timeout)
   );

   // sequencing: next state, index, request vector and sticky error flags
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      en_d    = en_q;
      req_d   = req_q;
      ack_d   = ack_q;
      abort_d = abort_q;
      err_set = '0;
      if (timeout) begin
         err_set[idx_q] = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (bus.pause_req_i) begin
               state_d  = PAUSE_STEP;
               idx_d    = '0;
               en_d     = bus.chan_en_i;
               req_d    = '0;
               req_d[0] = bus.chan_en_i[0];
               abort_d  = 1'b0;
            end
         end
         PAUSE_STEP: begin
            // an abort seen in the completing cycle itself counts as well
            abort_d = abort_q | ~bus.pause_req_i;
            if (step_done) begin
               if (abort_d) begin
                  state_d      = RESUME_STEP;
                  abort_d      = 1'b0;
                  req_d[idx_q] = 1'b0;
               end else if (idx_q == LAST_IDX) begin
                  state_d = PAUSED;
                  ack_d   = 1'b1;
               end else begin
                  idx_d        = idx_q + IDX_W'(1);
                  req_d[idx_d] = en_q[idx_d];
               end
            end
         end
         PAUSED: begin
            if (!bus.pause_req_i) begin
               state_d         = RESUME_STEP;
               idx_d           = LAST_IDX;
               req_d[LAST_IDX] = 1'b0;
            end
         end
         RESUME_STEP: begin
            if (step_done) begin
               if (bus.pause_req_i) begin
                  state_d      = PAUSE_STEP;
                  req_d[idx_q] = en_q[idx_q];
               end else if (idx_q == '0) begin
                  state_d = IDLE;
                  ack_d   = 1'b0;
               end else begin
                  idx_d        = idx_q - IDX_W'(1);
                  req_d[idx_d] = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // a set in the same cycle as a clear wins
      err_d = (bus.err_clr_i ? '0 : err_q) | err_set;
   end

   // state and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         en_q    <= '0;
         req_q   <= '0;
         err_q   <= '0;
         abort_q <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
         req_q   <= req_d;
         err_q   <= err_d;
         abort_q <= abort_d;
         ack_q   <= ack_d;
         busy_q  <= (state_d == PAUSE_STEP) || (state_d == RESUME_STEP);
      end
   end

   assign bus.chan_req_o  = req_q;
   assign bus.pause_ack_o = ack_q;
   assign bus.busy_o      = busy_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_adam_fabric_pause_seq.sv
// Bench for adam_fabric_pause_seq: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// step-level behavioural model.
module tb_adam_fabric_pause_seq;

   localparam int NC = 3;
   localparam int TO = 8;

   localparam int W_REQ  = 0;
   localparam int W_ACK  = 1;
   localparam int W_PACK = 2;
   localparam int W_ERR  = 3;
   localparam int W_BUSY = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   adam_fabric_pause_seq_if #(.NO_CHANS(NC)) bus ();

   adam_fabric_pause_seq #(.NO_CHANS(NC), .TIMEOUT(TO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 pausing, 2 paused, 3 resuming
   typedef struct {
      int          mode;
      int          idx;
      int          waited;
      bit          abort;
      bit [NC-1:0] en;
      bit [NC-1:0] req;
      bit [NC-1:0] err;
      bit          up_ack;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t s;
      s.mode = 0; s.idx = 0; s.waited = 0; s.abort = 0;
      s.en = '0; s.req = '0; s.err = '0; s.up_ack = 0;
      return s;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t s, input bit p, input bit [NC-1:0] en_in,
                                     input bit [NC-1:0] ack_in, input bit clr);
      mdl_t n = s;
      bit [NC-1:0] set = '0;
      bit done, to;
      if (s.mode == 0) begin
         if (p) begin
            n.mode = 1; n.idx = 0; n.en = en_in; n.req = '0;
            n.req[0] = en_in[0]; n.waited = 0; n.abort = 0;
         end
      end else if (s.mode == 2) begin
         if (!p) begin
            n.mode = 3; n.idx = NC - 1; n.req[NC-1] = 0;
         end
      end else begin
         if (s.mode == 1 && !p) n.abort = 1;
         done = !s.en[s.idx] || (ack_in[s.idx] == (s.mode == 1));
         to   = !done && (TO != 0) && (s.waited == TO - 1);
         if (to) set[s.idx] = 1;
         if (!(done || to)) begin
            n.waited = s.waited + 1;
         end else begin
            n.waited = 0;
            if (s.mode == 1) begin
               if (n.abort) begin
                  n.mode = 3; n.abort = 0; n.req[s.idx] = 0;
               end else if (s.idx == NC - 1) begin
                  n.mode = 2; n.up_ack = 1;
               end else begin
                  n.idx = s.idx + 1; n.req[n.idx] = s.en[n.idx];
               end
            end else begin
               if (p) begin
                  n.mode = 1; n.req[s.idx] = s.en[s.idx];
               end else if (s.idx == 0) begin
                  n.mode = 0; n.up_ack = 0;
               end else begin
                  n.idx = s.idx - 1; n.req[n.idx] = 0;
               end
            end
         end
      end
      if (clr) n.err = '0;
      n.err |= set;
      return n;
   endfunction

   initial begin
      m = mdl_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m = mdl_reset();
         else m = mdl_step(m, bus.pause_req_i, bus.chan_en_i, bus.chan_ack_i, bus.err_clr_i);
      end
   end

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         #2;
         chk("chan_req_o", bus.chan_req_o, m.req);
         chk("pause_ack_o", bus.pause_ack_o, m.up_ack);
         chk("busy_o", bus.busy_o, (m.mode == 1 || m.mode == 3));
         chk("err_o", bus.err_o, m.err);
      end
   end

   // ---------------- downstream channel responders ----------------
   int dly[NC];
   bit dead[NC];
   int rcnt[NC];

   initial begin
      bus.chan_ack_i = '0;
      for (int i = 0; i < NC; i++) rcnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NC; i++) begin
            logic tgt;
            tgt = bus.chan_req_o[i] && !dead[i];
            if (bus.chan_ack_i[i] !== tgt) begin
               rcnt[i]++;
               if (rcnt[i] >= dly[i]) begin
                  bus.chan_ack_i[i] = tgt;
                  rcnt[i] = 0;
               end
            end else begin
               rcnt[i] = 0;
            end
         end
      end
   end

   // ---------------- request-vector history ----------------
   logic [63:0]   seq;
   logic [NC-1:0] last_req;
   bit            ack_seen;

   initial begin
      seq = '0; last_req = '0; ack_seen = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.chan_req_o !== last_req) begin
            seq      = {seq[59:0], 1'b0, bus.chan_req_o};
            last_req = bus.chan_req_o;
         end
         if (bus.pause_ack_o) ack_seen = 1;
      end
   end

   task automatic seq_clr();
      seq = '0; last_req = bus.chan_req_o; ack_seen = 0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic get_sig(input int which, input int b);
      case (which)
         W_REQ:   return bus.chan_req_o[b];
         W_ACK:   return bus.chan_ack_i[b];
         W_PACK:  return bus.pause_ack_o;
         W_ERR:   return bus.err_o[b];
         default: return bus.busy_o;
      endcase
   endfunction

   task automatic wait_sig(input string nm, input int which, input int b, input logic v,
                           output int cyc);
      cyc = 0;
      while (get_sig(which, b) !== v && cyc < 300) begin
         step(1);
         cyc++;
      end
      if (get_sig(which, b) !== v) chk({nm, "_wait"}, get_sig(which, b), v);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- main stimulus ----------------
   int c;
   int hold;

   initial begin
      bus.pause_req_i = 0;
      bus.chan_en_i   = 3'b111;
      bus.err_clr_i   = 0;
      for (int i = 0; i < NC; i++) begin dly[i] = 2; dead[i] = 0; end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      step(3);
      chk("reset_outputs", {bus.chan_req_o, bus.pause_ack_o, bus.busy_o, bus.err_o}, '0);
      rst_n = 1'b1;
      step(2);

      // basic pause / resume
      seq_clr();
      bus.pause_req_i = 1;
      wait_sig("ack2_rise", W_ACK, 2, 1, c);
      wait_sig("pause_ack_rise", W_PACK, 0, 1, c);
      chk("pause_ack_latency", c, 1);
      chk("pause_order", seq, 64'h137);
      step(3);
      seq_clr();
      bus.pause_req_i = 0;
      wait_sig("ack0_fall", W_ACK, 0, 0, c);
      wait_sig("pause_ack_fall", W_PACK, 0, 0, c);
      chk("unpause_latency", c, 1);
      chk("resume_order", seq, 64'h310);
      step(3);

      // masked channel 1
      bus.chan_en_i = 3'b101;
      seq_clr();
      bus.pause_req_i = 1;
      wait_sig("m_ack0", W_ACK, 0, 1, c);
      wait_sig("m_req2", W_REQ, 2, 1, c);
      chk("masked_step_cost", c, 2);
      wait_sig("m_pack", W_PACK, 0, 1, c);
      chk("masked_pause_order", seq, 64'h15);
      seq_clr();
      bus.pause_req_i = 0;
      wait_sig("m_unpack", W_PACK, 0, 0, c);
      chk("masked_resume_order", seq, 64'h10);
      step(3);

      // all channels disabled
      bus.chan_en_i = 3'b000;
      bus.pause_req_i = 1;
      wait_sig("d_pack", W_PACK, 0, 1, c);
      chk("all_disabled_pause_cycles", c, 1 + NC);
      bus.pause_req_i = 0;
      wait_sig("d_unpack", W_PACK, 0, 0, c);
      chk("all_disabled_resume_cycles", c, 1 + NC);
      bus.chan_en_i = 3'b111;
      step(3);

      // timeout on dead channel 1
      dead[1] = 1;
      bus.pause_req_i = 1;
      wait_sig("t_req1", W_REQ, 1, 1, c);
      wait_sig("t_err1", W_ERR, 1, 1, c);
      chk("timeout_cycles", c, TO);
      chk("timeout_err", bus.err_o, 3'b010);
      wait_sig("t_pack", W_PACK, 0, 1, c);
      chk("paused_after_timeout", {bus.pause_ack_o, bus.chan_req_o}, 4'b1111);
      bus.err_clr_i = 1;
      step(1);
      bus.err_clr_i = 0;
      chk("err_clear", bus.err_o, 3'b000);
      bus.pause_req_i = 0;
      wait_sig("t_unpack", W_PACK, 0, 0, c);
      step(3);
      bus.pause_req_i = 1;
      wait_sig("t2_req1", W_REQ, 1, 1, c);
      step(TO - 1);
      bus.err_clr_i = 1;
      step(1);
      bus.err_clr_i = 0;
      chk("clear_vs_set", bus.err_o, 3'b010);
      wait_sig("t2_pack", W_PACK, 0, 1, c);
      bus.pause_req_i = 0;
      wait_sig("t2_unpack", W_PACK, 0, 0, c);
      dead[1] = 0;
      bus.err_clr_i = 1;
      step(1);
      bus.err_clr_i = 0;
      step(3);

      // abort while waiting on channel 1
      dly[1] = 4;
      seq_clr();
      bus.pause_req_i = 1;
      wait_sig("a_req1", W_REQ, 1, 1, c);
      bus.pause_req_i = 0;
      wait_sig("a_idle", W_BUSY, 0, 0, c);
      chk("abort_order", seq, 64'h1310);
      chk("abort_no_pause_ack", ack_seen, 0);
      step(6);

      // re-pause while channel 1 is releasing
      dly[1] = 3;
      bus.pause_req_i = 1;
      wait_sig("r_pack", W_PACK, 0, 1, c);
      seq_clr();
      bus.pause_req_i = 0;
      wait_sig("r_req1_fall", W_REQ, 1, 0, c);
      bus.pause_req_i = 1;
      wait_sig("r_repaused", W_BUSY, 0, 0, c);
      chk("repause_order", seq, 64'h3137);
      chk("repause_final", {bus.pause_ack_o, bus.chan_req_o}, 4'b1111);
      bus.pause_req_i = 0;
      wait_sig("r_unpack", W_PACK, 0, 0, c);
      step(3);

      // asynchronous reset mid pause step
      for (int i = 0; i < NC; i++) dly[i] = 5;
      bus.pause_req_i = 1;
      wait_sig("x_req1", W_REQ, 1, 1, c);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {bus.chan_req_o, bus.pause_ack_o, bus.busy_o, bus.err_o}, '0);
      bus.pause_req_i = 0;
      step(2);
      rst_n = 1'b1;
      step(4);
      chk("post_reset_idle", {bus.chan_req_o, bus.pause_ack_o, bus.busy_o}, '0);
      for (int i = 0; i < NC; i++) dly[i] = 2;
      step(8);

      // randomized traffic, checked by the per-cycle compare
      for (int it = 0; it < 150; it++) begin
         bus.chan_en_i = 3'($urandom_range(0, 7));
         for (int i = 0; i < NC; i++) begin
            dly[i]  = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(1, 4));
            dead[i] = ($urandom_range(0, 11) == 0);
         end
         bus.pause_req_i = ~bus.pause_req_i;
         hold = $urandom_range(1, 30);
         repeat (hold) begin
            bus.err_clr_i = ($urandom_range(0, 15) == 0);
            step(1);
         end
         bus.err_clr_i = 0;
      end
      bus.pause_req_i = 0;
      for (int i = 0; i < NC; i++) begin dly[i] = 1; dead[i] = 0; end
      step(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
